// File: rtl/karatsuba_pkg.sv
// Shared types and constants for the Karatsuba datapath blocks.
// Provides the half/full word split used by the pipelined subtractor
// and the stage-1 register bundle with its reset value.
package karatsuba_pkg;

  localparam int unsigned HALF_W = 16;
  localparam int unsigned FULL_W = 2 * HALF_W;

  typedef logic [HALF_W-1:0] half_t;
  typedef logic [FULL_W-1:0] word_t;

  // Everything stage 2 needs from stage 1: finished low half, the borrow
  // out of it, and the untouched high halves of both operands.
  typedef struct packed {
    half_t lo;
    logic  b1;
    half_t a_hi;
    half_t b_hi;
  } s1_t;

  localparam s1_t S1_RST = '0;

endpackage

// File: rtl/sub_16.sv
// Combinational WIDTH-bit subtractor with borrow-in/borrow-out.
// Ports:
//   a_i    minuend
//   b_i    subtrahend
//   bin_i  borrow-in
//   diff_o a_i - b_i - bin_i, modulo 2^WIDTH
//   bout_o 1 when a_i < b_i + bin_i (unsigned)
module sub_16
  import karatsuba_pkg::*;
#(
  parameter int unsigned WIDTH = HALF_W
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             bin_i,
  output logic [WIDTH-1:0] diff_o,
  output logic             bout_o
);

  logic [WIDTH:0] ext;

  // One extra bit: a negative result wraps and sets the top bit, which is
  // exactly the borrow-out.
  always_comb begin
    ext    = {1'b0, a_i} - {1'b0, b_i} - {{WIDTH{1'b0}}, bin_i};
    diff_o = ext[WIDTH-1:0];
    bout_o = ext[WIDTH];
  end

endmodule

// File: rtl/sub_32_pipe.sv
// Two-stage pipelined subtractor: diff = a - b - bin (mod 2^W), bout =
// unsigned borrow-out. Stage 1 subtracts the low halves; the borrow is
// registered and consumed by stage 2 on the high halves.
// Valid/ready handshake on both sides; 2-cycle latency, 1 result/cycle.
// Optional build macro SUB_SAT_EN: unsigned saturation, diff forced to 0
// whenever bout=1.
// Ports:
//   clk, rst_n           clock (rising edge), async active-low reset
//   in_valid, in_ready   input handshake
//   a, b, bin            minuend, subtrahend, borrow-in
//   out_valid, out_ready output handshake
//   diff, bout           result and borrow-out (held while not accepted)
// W is tied to the package word width (the stage bundle is typed there).
module sub_32_pipe
  import karatsuba_pkg::*;
#(
  parameter int unsigned W = FULL_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         bin,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] diff,
  output logic         bout
);

  logic         s1_valid_q, s1_valid_d;
  s1_t          s1_q, s1_d;
  logic         s2_valid_q, s2_valid_d;
  logic [W-1:0] diff_q, diff_d;
  logic         bout_q, bout_d;

  logic         adv2;
  logic         in_fire;
  logic         out_fire;

  logic [W/2-1:0] lo_c;
  logic [W/2-1:0] hi_c;
  logic           b1_c;
  logic           bout_c;

  sub_16 #(.WIDTH(W/2)) u_sub_lo (
    .a_i    (a[W/2-1:0]),
    .b_i    (b[W/2-1:0]),
    .bin_i  (bin),
    .diff_o (lo_c),
    .bout_o (b1_c)
  );

  sub_16 #(.WIDTH(W/2)) u_sub_hi (
    .a_i    (s1_q.a_hi),
    .b_i    (s1_q.b_hi),
    .bin_i  (s1_q.b1),
    .diff_o (hi_c),
    .bout_o (bout_c)
  );

  always_comb begin
    // in_ready depends on out_ready but never on in_valid.
    adv2     = s1_valid_q & (~s2_valid_q | out_ready);
    in_ready = ~s1_valid_q | adv2;
    in_fire  = in_valid & in_ready;
    out_fire = s2_valid_q & out_ready;

    s1_valid_d = s1_valid_q;
    s1_d       = s1_q;
    s2_valid_d = s2_valid_q;
    diff_d     = diff_q;
    bout_d     = bout_q;

    if (in_fire) begin
      s1_valid_d = 1'b1;
      s1_d       = '{lo: lo_c, b1: b1_c, a_hi: a[W-1:W/2], b_hi: b[W-1:W/2]};
    end else if (adv2) begin
      s1_valid_d = 1'b0;
    end

    if (adv2) begin
      s2_valid_d = 1'b1;
      bout_d     = bout_c;
`ifdef SUB_SAT_EN
      diff_d     = bout_c ? '0 : {hi_c, s1_q.lo};
`else
      diff_d     = {hi_c, s1_q.lo};
`endif
    end else if (out_fire) begin
      s2_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_q       <= S1_RST;
      s2_valid_q <= 1'b0;
      diff_q     <= '0;
      bout_q     <= 1'b0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_q       <= s1_d;
      s2_valid_q <= s2_valid_d;
      diff_q     <= diff_d;
      bout_q     <= bout_d;
    end
  end

  assign out_valid = s2_valid_q;
  assign diff      = diff_q;
  assign bout      = bout_q;

endmodule
